uart_baud_gen: RTL and testbench

//  Parametrised baud-rate generator; successor to the fixed 9600-baud bps_module.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_os_ctr.sv | 40 ++++
 rtl/uart_baud_gen.sv | 127 ++++++++++++
 tb/tb_uart_baud_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART divisor widths, baud config type and divisor helper
package uart_pkg;

  localparam int UART_DIV_W  = 16;
  localparam int UART_FRAC_W = 4;

  typedef struct packed {
    logic [UART_DIV_W-1:0]  div_int;
    logic [UART_FRAC_W-1:0] div_frac;
  } baud_cfg_t;

  // Integer clock cycles per bit; the fractional remainder is dropped.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_os_ctr.sv
// rtl/uart_os_ctr.sv - oversample counter, OS_RATE ticks per bit with the last
// interval stretched to end exactly on bit_end
module uart_os_ctr
  import uart_pkg::*;
#(
  parameter int CW      = UART_DIV_W + 1,
  parameter int OS_RATE = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_bit_end,
  input  logic [CW-1:0] i_os_div,
  output logic          o_os_tick
);

  localparam int             IW       = $clog2(OS_RATE);
  localparam logic [IW-1:0]  IDX_LAST = IW'(OS_RATE - 1);

  logic [CW-1:0] r_os_cnt;
  logic [IW-1:0] r_os_idx;
  logic          w_step;

  // The final interval never steps; it runs until the bit itself ends.
  assign w_step    = (r_os_cnt == i_os_div - CW'(1)) && (r_os_idx != IDX_LAST);
  assign o_os_tick = w_step || i_bit_end;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_os_cnt <= '0;
      r_os_idx <= '0;
    end else if (w_step) begin
      r_os_cnt <= '0;
      r_os_idx <= r_os_idx + IW'(1);
    end else begin
      r_os_cnt <= r_os_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - runtime-loadable fractional baud generator with mid-bit,
// end-of-bit and oversample strobes, gated by count_sig
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD_DEF = 9600,
  parameter int DIV_W    = UART_DIV_W,
  parameter int FRAC_W   = UART_FRAC_W,
  parameter int OS_RATE  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_count_sig,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_div_load,
  output logic              o_bps_clk,
  output logic              o_bit_end,
  output logic              o_os_tick,
  output logic              o_cfg_err
);

  localparam int               CW      = DIV_W + 1;
  localparam int               OS_LOG  = $clog2(OS_RATE);
  localparam logic [DIV_W-1:0] DIV_DEF = DIV_W'(baud_div(CLK_HZ, BAUD_DEF));
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2 * OS_RATE);

  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_period;
  logic [FRAC_W-1:0] r_acc;
  logic [DIV_W-1:0]  r_div_act;
  logic [FRAC_W-1:0] r_frac_act;
  logic              r_pend_vld;
  logic [DIV_W-1:0]  r_pend_int;
  logic [FRAC_W-1:0] r_pend_frac;
  logic              r_cfg_err;

  logic              w_load_ok;
  logic              w_wrap;
  logic [DIV_W-1:0]  w_sel_int;
  logic [FRAC_W-1:0] w_sel_frac;
  logic [FRAC_W-1:0] w_acc_nxt;
  logic              w_carry;
  logic [CW-1:0]     w_os_div;
  logic              w_os_tick;

  always_comb begin
    w_load_ok = i_div_load && (i_div_int >= DIV_MIN);
    w_wrap    = i_count_sig && (r_count == r_period - CW'(1));
    // Divisor for the next bit: an idle load takes effect at once, else a pending one.
    w_sel_int  = r_div_act;
    w_sel_frac = r_frac_act;
    if (!i_count_sig && w_load_ok) begin
      w_sel_int  = i_div_int;
      w_sel_frac = i_div_frac;
    end else if (r_pend_vld) begin
      w_sel_int  = r_pend_int;
      w_sel_frac = r_pend_frac;
    end
    w_acc_nxt = r_acc + w_sel_frac;
    // acc_nxt + frac overflows exactly when acc_nxt exceeds the complement of frac.
    w_carry   = (w_acc_nxt > ~w_sel_frac);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count     <= '0;
      r_period    <= {1'b0, DIV_DEF};
      r_acc       <= '0;
      r_div_act   <= DIV_DEF;
      r_frac_act  <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_int  <= '0;
      r_pend_frac <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= i_div_load && !w_load_ok;
      if (!i_count_sig) begin
        r_count    <= '0;
        r_acc      <= '0;
        r_div_act  <= w_sel_int;
        r_frac_act <= w_sel_frac;
        r_period   <= {1'b0, w_sel_int};
        r_pend_vld <= 1'b0;
      end else if (w_wrap) begin
        r_count    <= '0;
        r_acc      <= w_acc_nxt;
        r_div_act  <= w_sel_int;
        r_frac_act <= w_sel_frac;
        r_period   <= {1'b0, w_sel_int} + CW'(w_carry);
        r_pend_vld <= w_load_ok;
        if (w_load_ok) begin
          r_pend_int  <= i_div_int;
          r_pend_frac <= i_div_frac;
        end
      end else begin
        r_count <= r_count + CW'(1);
        if (w_load_ok) begin
          r_pend_vld  <= 1'b1;
          r_pend_int  <= i_div_int;
          r_pend_frac <= i_div_frac;
        end
      end
    end
  end

  assign w_os_div = {1'b0, r_div_act} >> OS_LOG;

  uart_os_ctr #(
    .CW      (CW),
    .OS_RATE (OS_RATE)
  ) u_os_ctr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (!i_count_sig || w_wrap),
    .i_bit_end (w_wrap),
    .i_os_div  (w_os_div),
    .o_os_tick (w_os_tick)
  );

  assign o_bps_clk = i_count_sig && (r_count == (r_period >> 1));
  assign o_bit_end = w_wrap;
  assign o_os_tick = i_count_sig && w_os_tick;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - scoreboard bench: expected strobe cycles queued by stimulus,
// popped and compared by a negedge monitor
module tb_uart_baud_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        count_sig;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        bps_clk, bit_end, os_tick, cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mon_exp;
  int q_bps[$];
  int q_end[$];
  int q_os[$];
  int q_err[$];

  uart_baud_gen dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_count_sig (count_sig),
    .i_div_int   (div_int),
    .i_div_frac  (div_frac),
    .i_div_load  (div_load),
    .o_bps_clk   (bps_clk),
    .o_bit_end   (bit_end),
    .o_os_tick   (os_tick),
    .o_cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bps_clk) begin
      checks++;
      if (q_bps.size() == 0) begin
        errors++; $display("FAIL bps_clk: strobe at cyc %0d, required none", cyc);
      end else begin
        mon_exp = q_bps.pop_front();
        if (mon_exp != cyc) begin
          errors++; $display("FAIL bps_clk: strobe at cyc %0d, required cyc %0d", cyc, mon_exp);
        end
      end
    end
    if (bit_end) begin
      checks++;
      if (q_end.size() == 0) begin
        errors++; $display("FAIL bit_end: strobe at cyc %0d, required none", cyc);
      end else begin
        mon_exp = q_end.pop_front();
        if (mon_exp != cyc) begin
          errors++; $display("FAIL bit_end: strobe at cyc %0d, required cyc %0d", cyc, mon_exp);
        end
      end
    end
    if (os_tick) begin
      checks++;
      if (q_os.size() == 0) begin
        errors++; $display("FAIL os_tick: strobe at cyc %0d, required none", cyc);
      end else begin
        mon_exp = q_os.pop_front();
        if (mon_exp != cyc) begin
          errors++; $display("FAIL os_tick: strobe at cyc %0d, required cyc %0d", cyc, mon_exp);
        end
      end
    end
    if (cfg_err) begin
      checks++;
      if (q_err.size() == 0) begin
        errors++; $display("FAIL cfg_err: pulse at cyc %0d, required none", cyc);
      end else begin
        mon_exp = q_err.pop_front();
        if (mon_exp != cyc) begin
          errors++; $display("FAIL cfg_err: pulse at cyc %0d, required cyc %0d", cyc, mon_exp);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  task automatic load(input int di, input int df);
    div_int  = 16'(di);
    div_frac = 4'(df);
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
  endtask

  // Queue the strobes of one bit starting at cycle st whose count stays below upto.
  task automatic push_bit(input int st, input int p, input int bps, input int osd, input int upto);
    if (bps < upto) q_bps.push_back(st + bps);
    for (int j = 1; j < 16; j++)
      if (osd * j - 1 < upto) q_os.push_back(st + osd * j - 1);
    if (p - 1 < upto) begin
      q_os.push_back(st + p - 1);
      q_end.push_back(st + p - 1);
    end
  endtask

  task automatic chk0(input string name, input logic v);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL %s: got %b during reset, required 0", name, v);
    end
  endtask

  task automatic chk_empty(input string name, input int n);
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL %s: %0d expected strobes never seen, required 0", name, n);
    end
  endtask

  initial begin
    int s;
    rst = 1'b1; count_sig = 1'b1; div_int = '0; div_frac = '0; div_load = 1'b0;
    step(3);
    chk0("reset bps_clk", bps_clk);
    chk0("reset bit_end", bit_end);
    chk0("reset os_tick", os_tick);
    chk0("reset cfg_err", cfg_err);

    // Default 5208-cycle bits; a rejected load in bit 2, reset mid bit 9 with a load pending.
    rst = 1'b0;
    s = cyc;
    for (int n = 0; n < 9; n++) push_bit(s + n * 5208, 5208, 2604, 325, 5208);
    push_bit(s + 9 * 5208, 5208, 2604, 325, 4000);
    q_err.push_back(s + 2 * 5208 + 1000 + 1);
    goto(s + 2 * 5208 + 1000);
    load(20, 0);
    goto(s + 9 * 5208 + 1000);
    load(600, 0);
    goto(s + 9 * 5208 + 4000);
    rst = 1'b1;
    step(1);
    rst = 1'b0;

    // Post-reset bit must be DIV_DEF, then the next bit is cut by count_sig at 3000.
    s = cyc;
    push_bit(s, 5208, 2604, 325, 5208);
    push_bit(s + 5208, 5208, 2604, 325, 3000);
    goto(s + 5208 + 3000);
    count_sig = 1'b0;
    step(20);
    count_sig = 1'b1;

    // Full bit after re-enable; 300 then 434 loaded mid-bit, the newer one wins.
    s = cyc;
    push_bit(s, 5208, 2604, 325, 5208);
    for (int k = 0; k < 3; k++) push_bit(s + 5208 + 434 * k, 434, 217, 27, 434);
    goto(s + 500);
    load(300, 0);
    goto(s + 1000);
    load(434, 0);
    goto(s + 5208 + 3 * 434);
    count_sig = 1'b0;
    step(1);

    // Fractional divisor 434 + 8/16 loaded while idle.
    load(434, 8);
    count_sig = 1'b1;
    s = cyc;
    push_bit(s, 434, 217, 27, 434);
    push_bit(s + 434, 435, 217, 27, 435);
    push_bit(s + 869, 434, 217, 27, 434);
    push_bit(s + 1303, 435, 217, 27, 435);
    goto(s + 1738);
    count_sig = 1'b0;
    step(10);

    chk_empty("bps_clk queue", q_bps.size());
    chk_empty("bit_end queue", q_end.size());
    chk_empty("os_tick queue", q_os.size());
    chk_empty("cfg_err queue", q_err.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
